// File: rtl/tl_axi_master.sv
// Inbound PCIe request engine: replays RX MemWr/MemRd TLPs as AXI4 bursts and
// returns each MemRd's read data as a single CplD TLP on the TX completion FIFOs.
module tl_axi_master #(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int TX_DEPTH_LG2   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [15:0]               config_bdf_i,

    input  logic                      p_hdr_empty_i,
    input  logic [127:0]              p_hdr_rdata_i,
    output logic                      p_hdr_rden_o,
    input  logic                      p_data_empty_i,
    input  logic [255:0]              p_data_rdata_i,
    output logic                      p_data_rden_o,
    input  logic                      np_hdr_empty_i,
    input  logic [127:0]              np_hdr_rdata_i,
    output logic                      np_hdr_rden_o,

    input  logic                      cpl_hdr_full_i,
    output logic [95:0]               cpl_hdr_wdata_o,
    output logic                      cpl_hdr_wren_o,
    input  logic                      cpl_data_full_i,
    output logic [255:0]              cpl_data_wdata_o,
    output logic                      cpl_data_wren_o,

    output logic                      awvalid,
    input  logic                      awready,
    output logic [AXI_ID_WIDTH-1:0]   awid,
    output logic [AXI_ADDR_WIDTH-1:0] awaddr,
    output logic [7:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,

    output logic                      wvalid,
    input  logic                      wready,
    output logic [255:0]              wdata,
    output logic [31:0]               wstrb,
    output logic                      wlast,

    input  logic                      bvalid,
    output logic                      bready,
    input  logic [AXI_ID_WIDTH-1:0]   bid,
    input  logic [1:0]                bresp,

    output logic                      arvalid,
    input  logic                      arready,
    output logic [AXI_ID_WIDTH-1:0]   arid,
    output logic [AXI_ADDR_WIDTH-1:0] araddr,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,

    input  logic                      rvalid,
    output logic                      rready,
    input  logic [AXI_ID_WIDTH-1:0]   rid,
    input  logic [255:0]              rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,

    output logic                      err_o
);

    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_AR, R_CPLH, R_DATA} r_state_t;

    // Address arrives byte-swapped in the header; a[1:0] is always zero.
    function automatic logic [63:0] hdr_addr(input logic [127:0] h);
        return {h[71:64], h[79:72], h[87:80], h[95:88],
                h[103:96], h[111:104], h[119:112], h[127:122], 2'b00};
    endfunction

    function automatic logic [9:0] hdr_len(input logic [127:0] h);
        return {h[17:16], h[31:24]};
    endfunction

    // (L-1)/8 on 10 bits wraps L=0 (1024 DW) to 127, i.e. 128 beats of 8 DW.
    function automatic logic [7:0] beats_m1(input logic [9:0] len);
        logic [9:0] lm1;
        lm1 = len - 10'd1;
        return {1'b0, lm1[9:3]};
    endfunction

    logic       run_reg;
    w_state_t   w_state_reg;
    logic [9:0] w_len_reg;
    logic [63:0] w_addr_reg;
    logic [7:0] w_cnt_reg;

    r_state_t   r_state_reg;
    logic [9:0] r_len_reg;
    logic [63:0] r_addr_reg;
    logic [15:0] r_req_reg;
    logic [9:0] r_tag_reg;
    logic       err_reg;

    logic       w_beat;
    logic       r_beat;
    logic       np_is_rd;
    logic [4:0] strb_shift;
    logic [11:0] byte_count;

    // Keeps the pop strobes quiet for the cycle reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_reg <= 1'b0;
        else        run_reg <= 1'b1;
    end

    assign p_hdr_rden_o  = run_reg && (w_state_reg == W_IDLE) && !p_hdr_empty_i;
    assign awvalid       = (w_state_reg == W_AW);
    assign awid          = '0;
    assign awaddr        = AXI_ADDR_WIDTH'(w_addr_reg);
    assign awlen         = beats_m1(w_len_reg);
    assign awsize        = 3'd5;
    assign awburst       = 2'b01;

    assign wvalid        = (w_state_reg == W_DATA) && !p_data_empty_i;
    assign wdata         = p_data_rdata_i;
    assign wlast         = (w_state_reg == W_DATA) && (w_cnt_reg == 8'd0);
    assign w_beat        = wvalid && wready;
    assign p_data_rden_o = w_beat;
    assign strb_shift    = {w_len_reg[2:0], 2'b00};
    assign wstrb         = (wlast && (w_len_reg[2:0] != 3'd0)) ?
                           ((32'd1 << strb_shift) - 32'd1) : 32'hFFFF_FFFF;
    assign bready        = (w_state_reg == W_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_reg <= W_IDLE;
            w_len_reg   <= '0;
            w_addr_reg  <= '0;
            w_cnt_reg   <= '0;
        end else begin
            case (w_state_reg)
                W_IDLE: if (p_hdr_rden_o) begin
                    w_len_reg   <= hdr_len(p_hdr_rdata_i);
                    w_addr_reg  <= hdr_addr(p_hdr_rdata_i);
                    w_state_reg <= W_AW;
                end
                W_AW: if (awready) begin
                    w_cnt_reg   <= beats_m1(w_len_reg);
                    w_state_reg <= W_DATA;
                end
                W_DATA: if (w_beat) begin
                    if (w_cnt_reg == 8'd0) w_state_reg <= W_RESP;
                    else                   w_cnt_reg   <= w_cnt_reg - 8'd1;
                end
                W_RESP: if (bvalid) w_state_reg <= W_IDLE;
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    // Non-MemRd entries on the NP queue are popped too, but only MemRd starts a read.
    assign np_hdr_rden_o   = run_reg && (r_state_reg == R_IDLE) && !np_hdr_empty_i;
    assign np_is_rd        = !np_hdr_rdata_i[6];
    assign arvalid         = (r_state_reg == R_AR);
    assign arid            = '0;
    assign araddr          = AXI_ADDR_WIDTH'(r_addr_reg);
    assign arlen           = beats_m1(r_len_reg);
    assign arsize          = 3'd5;
    assign arburst         = 2'b01;
    assign cpl_hdr_wren_o  = (r_state_reg == R_CPLH) && !cpl_hdr_full_i;
    assign rready          = (r_state_reg == R_DATA) && !cpl_data_full_i;
    assign r_beat          = rvalid && rready;
    assign cpl_data_wren_o = r_beat;
    assign cpl_data_wdata_o = rdata;
    assign byte_count      = {r_len_reg, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_reg <= R_IDLE;
            r_len_reg   <= '0;
            r_addr_reg  <= '0;
            r_req_reg   <= '0;
            r_tag_reg   <= '0;
        end else begin
            case (r_state_reg)
                R_IDLE: if (np_hdr_rden_o && np_is_rd) begin
                    r_len_reg   <= hdr_len(np_hdr_rdata_i);
                    r_addr_reg  <= hdr_addr(np_hdr_rdata_i);
                    r_req_reg   <= np_hdr_rdata_i[47:32];
                    r_tag_reg   <= {np_hdr_rdata_i[15], np_hdr_rdata_i[10], np_hdr_rdata_i[55:48]};
                    r_state_reg <= R_AR;
                end
                R_AR:   if (arready)         r_state_reg <= R_CPLH;
                R_CPLH: if (!cpl_hdr_full_i) r_state_reg <= R_DATA;
                R_DATA: if (r_beat && rlast) r_state_reg <= R_IDLE;
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    // CplD header: status SC and BCM clear even when the AXI read reported an error.
    always_comb begin
        cpl_hdr_wdata_o         = '0;
        cpl_hdr_wdata_o[7:5]    = 3'b010;
        cpl_hdr_wdata_o[4:0]    = 5'b01010;
        cpl_hdr_wdata_o[15]     = r_tag_reg[9];
        cpl_hdr_wdata_o[10]     = r_tag_reg[8];
        cpl_hdr_wdata_o[17:16]  = r_len_reg[9:8];
        cpl_hdr_wdata_o[31:24]  = r_len_reg[7:0];
        cpl_hdr_wdata_o[47:32]  = config_bdf_i;
        cpl_hdr_wdata_o[51:48]  = byte_count[11:8];
        cpl_hdr_wdata_o[63:56]  = byte_count[7:0];
        cpl_hdr_wdata_o[79:64]  = r_req_reg;
        cpl_hdr_wdata_o[87:80]  = r_tag_reg[7:0];
        cpl_hdr_wdata_o[94:88]  = r_addr_reg[6:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if ((bready && bvalid && (bresp != 2'b00)) ||
                     (r_beat && (rresp != 2'b00)) ||
                     (np_hdr_rden_o && !np_is_rd)) begin
            err_reg <= 1'b1;
        end
    end
    assign err_o = err_reg;

    wire [TX_DEPTH_LG2-1:0] unused_tx_depth = '0;
    wire unused_inputs = &{1'b0, p_hdr_rdata_i, np_hdr_rdata_i, bid, rid, unused_tx_depth};

endmodule

// File: tb/tb_tl_axi_master.sv
// Directed bench for tl_axi_master: FIFO and AXI slave models around the DUT,
// hand-computed expectations checked per transaction.
module tb_tl_axi_master;
    localparam int IDW = 4;
    localparam int AW  = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0]  config_bdf;
    logic         p_hdr_empty, p_hdr_rden, p_data_empty, p_data_rden, np_hdr_empty, np_hdr_rden;
    logic [127:0] p_hdr_rdata, np_hdr_rdata;
    logic [255:0] p_data_rdata;
    logic         cpl_hdr_full, cpl_hdr_wren, cpl_data_full, cpl_data_wren;
    logic [95:0]  cpl_hdr_wdata;
    logic [255:0] cpl_data_wdata;
    logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [IDW-1:0] awid, bid, arid, rid;
    logic [AW-1:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst, bresp, rresp;
    logic [255:0] wdata, rdata;
    logic [31:0]  wstrb;
    logic         arvalid, arready, rvalid, rready, rlast, err_o;

    tl_axi_master #(.AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .TX_DEPTH_LG2(4)) dut (
        .clk(clk), .rst_n(rst_n), .config_bdf_i(config_bdf),
        .p_hdr_empty_i(p_hdr_empty), .p_hdr_rdata_i(p_hdr_rdata), .p_hdr_rden_o(p_hdr_rden),
        .p_data_empty_i(p_data_empty), .p_data_rdata_i(p_data_rdata), .p_data_rden_o(p_data_rden),
        .np_hdr_empty_i(np_hdr_empty), .np_hdr_rdata_i(np_hdr_rdata), .np_hdr_rden_o(np_hdr_rden),
        .cpl_hdr_full_i(cpl_hdr_full), .cpl_hdr_wdata_o(cpl_hdr_wdata), .cpl_hdr_wren_o(cpl_hdr_wren),
        .cpl_data_full_i(cpl_data_full), .cpl_data_wdata_o(cpl_data_wdata), .cpl_data_wren_o(cpl_data_wren),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .err_o(err_o)
    );

    // Show-ahead FIFO models; a reset flushes whatever is still queued.
    logic [127:0] p_hdr_mem [0:15];
    logic [255:0] p_data_mem [0:15];
    logic [127:0] np_hdr_mem [0:15];
    int p_hdr_wr = 0, p_hdr_rd = 0, p_data_wr = 0, p_data_rd = 0, np_wr = 0, np_rd = 0;

    assign p_hdr_empty  = (p_hdr_wr == p_hdr_rd);
    assign p_hdr_rdata  = p_hdr_mem[p_hdr_rd[3:0]];
    assign p_data_empty = (p_data_wr == p_data_rd);
    assign p_data_rdata = p_data_mem[p_data_rd[3:0]];
    assign np_hdr_empty = (np_wr == np_rd);
    assign np_hdr_rdata = np_hdr_mem[np_rd[3:0]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_hdr_rd  <= p_hdr_wr;
            p_data_rd <= p_data_wr;
            np_rd     <= np_wr;
        end else begin
            if (p_hdr_rden)  p_hdr_rd  <= p_hdr_rd + 1;
            if (p_data_rden) p_data_rd <= p_data_rd + 1;
            if (np_hdr_rden) np_rd     <= np_rd + 1;
        end
    end

    // AXI slave models
    logic [1:0]  bresp_cfg;
    int          err_beat;
    logic [31:0] rbase;
    int          r_beat_idx, r_last_idx;

    function automatic logic [255:0] rpat(input int i);
        return {8{rbase + 32'(i)}};
    endfunction

    assign bid = '0;
    assign rid = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bvalid <= 1'b0;
            bresp  <= 2'b00;
        end else if (wvalid && wready && wlast) begin
            bvalid <= 1'b1;
            bresp  <= bresp_cfg;
        end else if (bvalid && bready) begin
            bvalid <= 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0; rlast <= 1'b0; rdata <= '0; rresp <= 2'b00;
            r_beat_idx <= 0; r_last_idx <= 0;
        end else if (arvalid && arready && !rvalid) begin
            rvalid <= 1'b1; r_beat_idx <= 0; r_last_idx <= int'(arlen);
            rdata <= rpat(0); rlast <= (arlen == 8'd0);
            rresp <= (err_beat == 0) ? 2'b10 : 2'b00;
        end else if (rvalid && rready) begin
            if (rlast) begin
                rvalid <= 1'b0;
            end else begin
                r_beat_idx <= r_beat_idx + 1;
                rdata <= rpat(r_beat_idx + 1);
                rlast <= (r_beat_idx + 1 == r_last_idx);
                rresp <= (err_beat == r_beat_idx + 1) ? 2'b10 : 2'b00;
            end
        end
    end

    // Transaction monitor
    int cyc = 0, hdr_pop_cyc = 0, aw_rise_cyc = 0;
    logic aw_prev = 1'b0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, ch_cnt = 0, cd_cnt = 0, pd_pop_cnt = 0, np_pop_cnt = 0;
    logic [63:0]  aw_addr_log [0:15];
    logic [7:0]   aw_len_log  [0:15];
    logic [255:0] w_data_log  [0:15];
    logic [31:0]  w_strb_log  [0:15];
    logic         w_last_log  [0:15];
    logic [63:0]  ar_addr_log [0:15];
    logic [7:0]   ar_len_log  [0:15];
    logic [95:0]  ch_log      [0:15];
    logic [255:0] cd_log      [0:255];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        aw_prev <= awvalid;
        if (rst_n) begin
            if (p_hdr_rden) hdr_pop_cyc <= cyc;
            if (awvalid && !aw_prev) aw_rise_cyc <= cyc;
            if (awvalid && awready) begin
                aw_addr_log[aw_cnt[3:0]] <= awaddr; aw_len_log[aw_cnt[3:0]] <= awlen; aw_cnt <= aw_cnt + 1;
            end
            if (wvalid && wready) begin
                w_data_log[w_cnt[3:0]] <= wdata; w_strb_log[w_cnt[3:0]] <= wstrb;
                w_last_log[w_cnt[3:0]] <= wlast; w_cnt <= w_cnt + 1;
            end
            if (p_data_rden) pd_pop_cnt <= pd_pop_cnt + 1;
            if (bvalid && bready) b_cnt <= b_cnt + 1;
            if (arvalid && arready) begin
                ar_addr_log[ar_cnt[3:0]] <= araddr; ar_len_log[ar_cnt[3:0]] <= arlen; ar_cnt <= ar_cnt + 1;
            end
            if (cpl_hdr_wren) begin ch_log[ch_cnt[3:0]] <= cpl_hdr_wdata; ch_cnt <= ch_cnt + 1; end
            if (cpl_data_wren) begin cd_log[cd_cnt[7:0]] <= cpl_data_wdata; cd_cnt <= cd_cnt + 1; end
            if (np_hdr_rden) np_pop_cnt <= np_pop_cnt + 1;
        end
    end

    int tests = 0, fails = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [127:0] mk_req(input logic [2:0] fmt, input logic [9:0] len,
                                            input logic [15:0] req, input logic [9:0] tag,
                                            input logic [63:0] a);
        logic [127:0] h;
        h = '0;
        h[7:5] = fmt; h[15] = tag[9]; h[10] = tag[8];
        h[17:16] = len[9:8]; h[31:24] = len[7:0];
        h[47:32] = req; h[55:48] = tag[7:0];
        h[71:64] = a[63:56]; h[79:72] = a[55:48]; h[87:80] = a[47:40]; h[95:88] = a[39:32];
        h[103:96] = a[31:24]; h[111:104] = a[23:16]; h[119:112] = a[15:8];
        h[127:122] = a[7:2]; h[121:120] = 2'b11;
        return h;
    endfunction

    task automatic push_p_hdr(input logic [127:0] h);
        p_hdr_mem[p_hdr_wr[3:0]] = h; p_hdr_wr = p_hdr_wr + 1;
    endtask
    task automatic push_p_data(input logic [255:0] d);
        p_data_mem[p_data_wr[3:0]] = d; p_data_wr = p_data_wr + 1;
    endtask
    task automatic push_np(input logic [127:0] h);
        np_hdr_mem[np_wr[3:0]] = h; np_wr = np_wr + 1;
    endtask

    task automatic check_cplh(input string tag, input logic [95:0] h, input logic [9:0] len,
                              input logic [11:0] bc, input logic [15:0] req,
                              input logic [9:0] tg, input logic [6:0] la);
        check({tag, "_fmt_type"}, {h[7:5], h[4:0]}, 8'h4A);
        check({tag, "_length"}, {h[17:16], h[31:24]}, len);
        check({tag, "_completer"}, h[47:32], 16'hBEEF);
        check({tag, "_status_bcm"}, h[55:52], 4'h0);
        check({tag, "_byte_count"}, {h[51:48], h[63:56]}, bc);
        check({tag, "_req_id"}, h[79:64], req);
        check({tag, "_tag"}, {h[15], h[10], h[87:80]}, tg);
        check({tag, "_lower_addr"}, h[94:88], la);
    endtask

    localparam logic [255:0] D0 = {8{32'hD000_0000}};
    localparam logic [255:0] D1 = {8{32'hD111_1111}};
    localparam logic [255:0] D2 = {8{32'hD222_2222}};
    localparam logic [255:0] D3 = {8{32'hD333_3333}};
    localparam logic [255:0] D4 = {8{32'hD444_4444}};
    localparam logic [255:0] D5 = {8{32'hD555_5555}};

    initial begin
        int aw0, w0, b0, ar0, ch0, cd0, pd0, np0;
        config_bdf = 16'hBEEF;
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        cpl_hdr_full = 1'b0; cpl_data_full = 1'b0;
        bresp_cfg = 2'b00; err_beat = -1; rbase = '0;

        tick(2);
        check("reset_outputs", {awvalid, wvalid, bready, arvalid, rready, p_hdr_rden, p_data_rden,
                                np_hdr_rden, cpl_hdr_wren, cpl_data_wren, err_o}, 11'b0);
        rst_n = 1'b1;
        tick(2);

        // 1: MemWr L=16, AW back-pressured for a few cycles
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; pd0 = pd_pop_cnt;
        awready = 1'b0;
        push_p_hdr(mk_req(3'b011, 10'd16, 16'h0, 10'h0, 64'h0000_0001_2345_6780));
        push_p_data(D0); push_p_data(D1);
        for (int t = 0; t < 50 && !awvalid; t++) @(negedge clk);
        tick(3);
        check("t1_awvalid_held", awvalid, 1'b1);
        check("t1_awaddr", awaddr, 64'h0000_0001_2345_6780);
        check("t1_awlen", awlen, 8'd1);
        check("t1_awsize_burst_id", {awsize, awburst, awid}, {3'd5, 2'b01, 4'h0});
        check("t1_aw_after_pop", 32'(aw_rise_cyc - hdr_pop_cyc), 32'd1);
        awready = 1'b1;
        for (int t = 0; t < 50 && b_cnt == b0; t++) @(negedge clk);
        check("t1_b_done", 32'(b_cnt - b0), 32'd1);
        check("t1_aw_count", 32'(aw_cnt - aw0), 32'd1);
        check("t1_w_beats", 32'(w_cnt - w0), 32'd2);
        check("t1_wdata0", w_data_log[w0], D0);
        check("t1_wdata1", w_data_log[w0 + 1], D1);
        check("t1_wstrb0", w_strb_log[w0], 32'hFFFF_FFFF);
        check("t1_wstrb1", w_strb_log[w0 + 1], 32'hFFFF_FFFF);
        check("t1_wlast", {w_last_log[w0], w_last_log[w0 + 1]}, 2'b01);
        check("t1_pdata_pops", 32'(pd_pop_cnt - pd0), 32'd2);

        // 2: MemWr L=4, P data arrives late
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        push_p_hdr(mk_req(3'b011, 10'd4, 16'h0, 10'h0, 64'h0000_0000_0000_1000));
        for (int t = 0; t < 50 && aw_cnt == aw0; t++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t2_wvalid_while_empty", {wvalid, p_data_rden}, 2'b00);
        end
        push_p_data(D2);
        for (int t = 0; t < 50 && b_cnt == b0; t++) @(negedge clk);
        check("t2_b_done", 32'(b_cnt - b0), 32'd1);
        check("t2_awaddr", aw_addr_log[aw0], 64'h1000);
        check("t2_awlen", aw_len_log[aw0], 8'd0);
        check("t2_w_beats", 32'(w_cnt - w0), 32'd1);
        check("t2_wstrb", w_strb_log[w0], 32'h0000_FFFF);
        check("t2_wlast", w_last_log[w0], 1'b1);
        check("t2_wdata", w_data_log[w0], D2);

        // 3: MemRd L=32 tag 0x2A5 requester 0x0100
        ar0 = ar_cnt; ch0 = ch_cnt; cd0 = cd_cnt;
        rbase = 32'h3300_0000;
        push_np(mk_req(3'b001, 10'd32, 16'h0100, 10'h2A5, 64'h0000_0002_8000_00C4));
        for (int t = 0; t < 100 && cd_cnt < cd0 + 4; t++) @(negedge clk);
        check("t3_ar_count", 32'(ar_cnt - ar0), 32'd1);
        check("t3_araddr", ar_addr_log[ar0], 64'h0000_0002_8000_00C4);
        check("t3_arlen", ar_len_log[ar0], 8'd3);
        check("t3_arsize_burst_id", {arsize, arburst, arid}, {3'd5, 2'b01, 4'h0});
        check("t3_cplh_count", 32'(ch_cnt - ch0), 32'd1);
        check_cplh("t3_cplh", ch_log[ch0], 10'd32, 12'd128, 16'h0100, 10'h2A5, 7'h44);
        check("t3_cpld_count", 32'(cd_cnt - cd0), 32'd4);
        check("t3_cpld0", cd_log[cd0], {8{32'h3300_0000}});
        for (int k = 1; k < 4; k++) check("t3_cpld", cd_log[cd0 + k], rpat(k));
        check("t3_err", err_o, 1'b0);

        // 4: TX Cpl data FIFO full while read data is pending
        ch0 = ch_cnt; cd0 = cd_cnt;
        cpl_data_full = 1'b1;
        rbase = 32'h4400_0000;
        push_np(mk_req(3'b001, 10'd24, 16'h0200, 10'h011, 64'h0000_0000_0000_0100));
        for (int t = 0; t < 50 && ch_cnt == ch0; t++) @(negedge clk);
        tick(4);
        check("t4_stall", {rvalid, rready, cpl_data_wren}, 3'b100);
        check("t4_no_writes", 32'(cd_cnt - cd0), 32'd0);
        cpl_data_full = 1'b0;
        for (int t = 0; t < 50 && cd_cnt < cd0 + 3; t++) @(negedge clk);
        check("t4_cpld_count", 32'(cd_cnt - cd0), 32'd3);
        for (int k = 0; k < 3; k++) check("t4_cpld", cd_log[cd0 + k], rpat(k));
        check_cplh("t4_cplh", ch_log[ch0], 10'd24, 12'd96, 16'h0200, 10'h011, 7'h00);

        // 5: MemRd L=0 (1024 DW) with an error response on beat 3
        ar0 = ar_cnt; ch0 = ch_cnt; cd0 = cd_cnt;
        check("t5_err_before", err_o, 1'b0);
        rbase = 32'h5500_0000;
        err_beat = 3;
        push_np(mk_req(3'b001, 10'd0, 16'h0300, 10'h3FF, 64'h0));
        for (int t = 0; t < 800 && cd_cnt < cd0 + 128; t++) @(negedge clk);
        check("t5_arlen", ar_len_log[ar0], 8'd127);
        check_cplh("t5_cplh", ch_log[ch0], 10'd0, 12'd0, 16'h0300, 10'h3FF, 7'h00);
        check("t5_cpld_count", 32'(cd_cnt - cd0), 32'd128);
        check("t5_cpld_err_beat", cd_log[cd0 + 3], rpat(3));
        check("t5_cpld_last", cd_log[cd0 + 127], rpat(127));
        check("t5_err_set", err_o, 1'b1);
        tick(5);
        check("t5_err_sticky", err_o, 1'b1);
        err_beat = -1;

        // 6: asynchronous reset in the middle of a write burst
        wready = 1'b0;
        push_p_hdr(mk_req(3'b011, 10'd16, 16'h0, 10'h0, 64'h0000_0000_0000_2000));
        push_p_data(D3); push_p_data(D4);
        for (int t = 0; t < 50 && !wvalid; t++) @(negedge clk);
        check("t6_in_wdata", wvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("t6_async_reset", {awvalid, wvalid, bready, arvalid, rready, p_hdr_rden, p_data_rden,
                                    np_hdr_rden, cpl_hdr_wren, cpl_data_wren, err_o}, 11'b0);
        tick(2);
        rst_n = 1'b1;
        wready = 1'b1;
        tick(1);
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        push_p_hdr(mk_req(3'b011, 10'd8, 16'h0, 10'h0, 64'h0000_00AB_CDEF_0100));
        push_p_data(D5);
        for (int t = 0; t < 50 && b_cnt == b0; t++) @(negedge clk);
        check("t6_b_done", 32'(b_cnt - b0), 32'd1);
        check("t6_awaddr", aw_addr_log[aw0], 64'h0000_00AB_CDEF_0100);
        check("t6_awlen", aw_len_log[aw0], 8'd0);
        check("t6_w_beats", 32'(w_cnt - w0), 32'd1);
        check("t6_wbeat", {w_data_log[w0], w_strb_log[w0], w_last_log[w0]}, {D5, 32'hFFFF_FFFF, 1'b1});
        check("t6_err", err_o, 1'b0);

        // 7: non-MemRd on the NP queue is dropped and flagged
        ar0 = ar_cnt; np0 = np_pop_cnt;
        push_np(mk_req(3'b011, 10'd1, 16'h0, 10'h0, 64'h0));
        tick(5);
        check("t7_np_popped", 32'(np_pop_cnt - np0), 32'd1);
        check("t7_no_ar", {32'(ar_cnt - ar0), arvalid}, 33'd0);
        check("t7_err", err_o, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
